// File: rtl/sys_pkg.sv
// Shared types for the TX frame scheduler slice: FSM state encoding and
// requester source identifiers.
package sys_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_ACK  = 2'b11,
        WAIT_DONE = 2'b10
    } state_e;

    typedef enum logic {
        SRC_RF  = 1'b0,
        SRC_ALU = 1'b1
    } src_e;

    localparam logic [1:0] RF_BYTES  = 2'd1;
    localparam logic [1:0] ALU_BYTES = 2'd2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; grant[0] is the RF requester, grant[1] the ALU.
// Purely combinational: the caller owns and updates last_grant.
module rr_arbiter2
    import sys_pkg::*;
(
    input  logic [1:0] req,
    input  logic       enable,
    input  src_e       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (enable) begin
            if (req == 2'b11) begin
                grant = (last_grant == SRC_ALU) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares the UART transmit path between RF read data (1 byte) and ALU results
// (2 bytes, low first), keeping exactly one frame in flight at a time.
module tx_frame_scheduler
    import sys_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ACK_TIMEOUT = 16
)
(
    input  logic                    clk,
    input  logic                    ARSTn,
    input  logic                    rf_valid,
    input  logic [DATA_WIDTH-1:0]   rf_data,
    output logic                    rf_ready,
    input  logic                    alu_valid,
    input  logic [2*DATA_WIDTH-1:0] alu_data,
    output logic                    alu_ready,
    input  logic                    tx_busy,
    output logic                    tx_valid,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    sched_busy
);

    localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    // Leaving WAIT_ACK as the counter steps to ACK_TIMEOUT-1 puts the re-issue
    // exactly ACK_TIMEOUT cycles after the previous ISSUE.
    localparam logic [CW-1:0] CNT_EXPIRE = CW'(ACK_TIMEOUT - 2);

    state_e                  state;
    logic [2*DATA_WIDTH-1:0] holding;
    logic [1:0]              bytes_left;
    logic [CW-1:0]           cnt;
    src_e                    last_grant;
    logic [1:0]              grant;
    logic                    arb_en;

    // Reset gates the grant so the ready strobes are low while ARSTn is held.
    assign arb_en = ARSTn && (state == IDLE) && !tx_busy;

    rr_arbiter2 u_arb (
        .req        ({alu_valid, rf_valid}),
        .enable     (arb_en),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign rf_ready  = grant[0];
    assign alu_ready = grant[1];
    assign tx_data   = holding[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            state      <= IDLE;
            holding    <= '0;
            bytes_left <= '0;
            cnt        <= '0;
            last_grant <= SRC_ALU;
            tx_valid   <= 1'b0;
            sched_busy <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rf_ready || alu_ready) begin
                        if (alu_ready) begin
                            holding    <= alu_data;
                            bytes_left <= ALU_BYTES;
                            last_grant <= SRC_ALU;
                        end else begin
                            holding    <= {{DATA_WIDTH{1'b0}}, rf_data};
                            bytes_left <= RF_BYTES;
                            last_grant <= SRC_RF;
                        end
                        state      <= ISSUE;
                        tx_valid   <= 1'b1;
                        sched_busy <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    cnt <= cnt + 1'b1;
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_EXPIRE) begin
                        state    <= ISSUE;
                        tx_valid <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        bytes_left <= bytes_left - 1'b1;
                        if (bytes_left == ALU_BYTES) begin
                            holding  <= holding >> DATA_WIDTH;
                            state    <= ISSUE;
                            tx_valid <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            sched_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    sched_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scoreboard bench for tx_frame_scheduler: requesters push expected frames,
// a monitor pops and compares every tx_valid pulse, a model plays the UART TX.
module tb_tx_frame_scheduler;

    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 5;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            ARSTn;
    logic            rf_valid;
    logic [DW-1:0]   rf_data;
    logic            rf_ready;
    logic            alu_valid;
    logic [2*DW-1:0] alu_data;
    logic            alu_ready;
    logic            tx_busy;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            sched_busy;

    logic model_en, model_busy, force_busy;
    int   busy_len, ignore_target, n_ignored;
    int   n_vec, n_err, n_frames;
    int   cyc = 0;
    exp_t sb[$];

    assign tx_busy = model_en ? model_busy : force_busy;

    tx_frame_scheduler #(.DATA_WIDTH(DW), .ACK_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .ARSTn      (ARSTn),
        .rf_valid   (rf_valid),
        .rf_data    (rf_data),
        .rf_ready   (rf_ready),
        .alu_valid  (alu_valid),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .tx_busy    (tx_busy),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .sched_busy (sched_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // retry=1: the TX model ignores the first pulse, so the same byte reappears TMO cycles later
    task automatic req_rf(input logic [DW-1:0] d, input bit retry, output int acc);
        int k;
        acc = -1;
        @(negedge clk);
        rf_data  = d;
        rf_valid = 1'b1;
        for (k = 0; k < 300; k++) begin
            #1;
            if (rf_ready) break;
            @(negedge clk);
        end
        if (k == 300) begin
            fail_now("rf_accept");
            rf_valid = 1'b0;
            return;
        end
        acc = cyc;
        sb.push_back('{data: d, cyc: acc + 1});
        if (retry) sb.push_back('{data: d, cyc: acc + 1 + TMO});
        @(negedge clk);
        rf_valid = 1'b0;
        #1 check("rf_ready_one_cycle", rf_ready, 1'b0);
    endtask

    task automatic req_alu(input logic [2*DW-1:0] d, input bit push_hi, output int acc);
        int k;
        acc = -1;
        @(negedge clk);
        alu_data  = d;
        alu_valid = 1'b1;
        for (k = 0; k < 300; k++) begin
            #1;
            if (alu_ready) break;
            @(negedge clk);
        end
        if (k == 300) begin
            fail_now("alu_accept");
            alu_valid = 1'b0;
            return;
        end
        acc = cyc;
        sb.push_back('{data: d[DW-1:0], cyc: acc + 1});
        if (push_hi) sb.push_back('{data: d[2*DW-1:DW], cyc: acc + busy_len + 2});
        @(negedge clk);
        alu_valid = 1'b0;
        #1 check("alu_ready_one_cycle", alu_ready, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!sched_busy && !tx_busy && sb.size() == 0) break;
        end
        if (k == 300) fail_now(name);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, acc, nf;
        n_vec = 0; n_err = 0; n_frames = 0;
        ARSTn = 1'b0; rf_valid = 1'b0; rf_data = '0; alu_valid = 1'b0; alu_data = '0;
        model_en = 1'b1; model_busy = 1'b0; force_busy = 1'b0;
        busy_len = 4; ignore_target = 0; n_ignored = 0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(posedge clk);
                    #1;
                    if (tx_valid) begin
                        n_frames++;
                        if (sb.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_frame: got tx_data 0x%0h, expected no frame (cycle %0d)", tx_data, cyc);
                        end else begin
                            e = sb.pop_front();
                            check("frame_data", tx_data, e.data);
                            check("frame_cycle", cyc, e.cyc);
                        end
                    end
                end
            end
            begin : tx_model
                forever begin
                    @(posedge clk);
                    #2;
                    if (tx_valid && model_en) begin
                        if (n_ignored < ignore_target) begin
                            n_ignored++;
                        end else begin
                            model_busy = 1'b1;
                            repeat (busy_len) @(posedge clk);
                            #2;
                            model_busy = 1'b0;
                        end
                    end
                end
            end
        join_none

        // reset values, with requests held to show the ready strobes stay low
        rf_valid = 1'b1; alu_valid = 1'b1;
        #2;
        check("rst_rf_ready", rf_ready, 1'b0);
        check("rst_alu_ready", alu_ready, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_sched_busy", sched_busy, 1'b0);
        rf_valid = 1'b0; alu_valid = 1'b0;
        repeat (2) @(negedge clk);
        ARSTn = 1'b1;
        #1 check("post_rst_sched_busy", sched_busy, 1'b0);

        // contention from reset: RF wins, then ALU wins over the re-raised RF request
        fork
            begin
                req_rf(8'h5A, 1'b0, a1);
                req_rf(8'h77, 1'b0, a3);
            end
            req_alu(16'hBEEF, 1'b1, a2);
        join
        wait_idle("contention_idle");

        // RF only, with sched_busy release timing
        req_rf(8'hA5, 1'b0, acc);
        while (cyc != acc + busy_len + 1) @(negedge clk);
        check("rf_busy_low_sampled", tx_busy, 1'b0);
        check("rf_sched_busy_hold", sched_busy, 1'b1);
        @(negedge clk);
        check("rf_sched_busy_drop", sched_busy, 1'b0);
        wait_idle("rf_idle");

        // ALU only: low byte then high byte
        req_alu(16'h1234, 1'b1, acc);
        wait_idle("alu_idle");

        // ack timeout: first pulse ignored, same byte re-issued
        ignore_target = n_ignored + 1;
        req_rf(8'h69, 1'b1, acc);
        wait_idle("timeout_idle");

        // busy gating in IDLE
        @(negedge clk);
        model_en   = 1'b0;
        force_busy = 1'b1;
        rf_data    = 8'h3C;
        rf_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("gate_no_ready", rf_ready, 1'b0);
            @(negedge clk);
        end
        force_busy = 1'b0;
        #1 check("gate_ready_first_low", rf_ready, 1'b1);
        sb.push_back('{data: 8'h3C, cyc: cyc + 1});
        model_en = 1'b1;
        @(negedge clk);
        rf_valid = 1'b0;
        wait_idle("gate_idle");

        // reset during WAIT_DONE of the ALU low byte drops the high byte
        busy_len = 6;
        req_alu(16'hCAFE, 1'b0, acc);
        while (cyc != acc + 4) @(negedge clk);
        check("midframe_busy", sched_busy, 1'b1);
        nf = n_frames;
        ARSTn = 1'b0;
        #1;
        check("midrst_tx_valid", tx_valid, 1'b0);
        check("midrst_tx_data", tx_data, 8'h00);
        check("midrst_sched_busy", sched_busy, 1'b0);
        check("midrst_alu_ready", alu_ready, 1'b0);
        repeat (2) @(negedge clk);
        ARSTn = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_high_byte", n_frames, nf);
        check("midrst_idle", sched_busy, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
